rh_axi4_slv_wr_ctrl: RTL and testbench

RH_AXI4_SLV_WR_CTRL -- requirements
Module: rh_axi4_slv_wr_ctrl

---
 rtl/rh_axi4_vip_pkg.sv | 29 ++
 rtl/rh_axi4_addr_gen.sv | 31 +++
 rtl/rh_axi4_slv_wr_ctrl.sv | 161 ++++++++++++++++
 tb/tb_rh_axi4_slv_wr_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rh_axi4_vip_pkg.sv
// rtl/rh_axi4_vip_pkg.sv - shared AXI4 burst/response encodings and write-FSM states
package rh_axi4_vip;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_DATA = 2'b01,
      ST_RESP = 2'b10
   } wr_state_e;

   // Only 2, 4, 8 or 16 beat wrapping bursts are legal.
   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/rh_axi4_addr_gen.sv
// rtl/rh_axi4_addr_gen.sv - combinational next-beat address for FIXED/INCR/WRAP bursts
module rh_axi4_addr_gen
   import rh_axi4_vip::*;
#(
   parameter int AW = 32
) (
   input  logic [AW-1:0] addr_i,
   input  logic [2:0]    size_i,
   input  logic [7:0]    len_i,
   input  logic [1:0]    burst_i,
   output logic [AW-1:0] next_addr_o
);

   logic [AW-1:0] incr;
   logic [AW-1:0] wmask;
   logic [AW-1:0] aligned;

   always_comb begin
      incr        = AW'(1) << size_i;
      wmask       = ((AW'(len_i) + AW'(1)) << size_i) - AW'(1);
      aligned     = addr_i & ~(incr - AW'(1));
      next_addr_o = aligned + incr;
      case (burst_i)
         BURST_FIXED: next_addr_o = addr_i;
         // Wrap keeps the upper bits of the window and rolls the low bits.
         BURST_WRAP:  next_addr_o = (addr_i & ~wmask) | ((addr_i + incr) & wmask);
         default:     next_addr_o = aligned + incr;
      endcase
   end

endmodule

// File: rtl/rh_axi4_slv_wr_ctrl.sv
// rtl/rh_axi4_slv_wr_ctrl.sv - AXI4 slave write channel controller driving a memory write port
// Optional macro RH_AXI4_SLV_WLAST_CHECK_EN: flag SLVERR when WLAST disagrees with the beat count.
module rh_axi4_slv_wr_ctrl
   import rh_axi4_vip::*;
#(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int IW = 4
) (
   input  logic            ACLK,
   input  logic            ARESETN,
   input  logic            AWVALID,
   output logic            AWREADY,
   input  logic [AW-1:0]   AWADDR,
   input  logic [7:0]      AWLEN,
   input  logic [2:0]      AWSIZE,
   input  logic [1:0]      AWBURST,
   input  logic [IW-1:0]   AWID,
   input  logic            WVALID,
   output logic            WREADY,
   input  logic [DW-1:0]   WDATA,
   input  logic [DW/8-1:0] WSTRB,
   input  logic            WLAST,
   output logic            BVALID,
   input  logic            BREADY,
   output logic [IW-1:0]   BID,
   output logic [1:0]      BRESP,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_wstrb
);

   localparam logic [2:0] SZ_MAX = 3'($clog2(DW / 8));

   wr_state_e       state_q;
   logic [AW-1:0]   addr_q;
   logic [AW-1:0]   next_addr_d;
   logic [7:0]      len_q;
   logic [7:0]      cnt_q;
   logic [2:0]      size_q;
   logic [1:0]      burst_q;
   logic [IW-1:0]   id_q;
   logic            aw_err_q;
   logic            wl_err_q;
   logic            awready_q;
   logic            wready_q;
   logic            bvalid_q;
   logic [1:0]      bresp_q;
   logic [IW-1:0]   bid_q;
   logic            mem_we_q;
   logic [AW-1:0]   mem_addr_q;
   logic [DW-1:0]   mem_wdata_q;
   logic [DW/8-1:0] mem_wstrb_q;

   logic aw_err_d;
   logic last_beat_d;
   logic wlast_bad_d;

   assign aw_err_d = (AWSIZE > SZ_MAX)
                   || (AWBURST == BURST_RSVD)
                   || ((AWBURST == BURST_WRAP) && !wrap_len_ok(AWLEN));
   assign last_beat_d = (cnt_q == len_q);

`ifdef RH_AXI4_SLV_WLAST_CHECK_EN
   assign wlast_bad_d = (WLAST != last_beat_d);
`else
   logic unused_wlast;
   assign unused_wlast = WLAST;
   assign wlast_bad_d  = 1'b0;
`endif

   rh_axi4_addr_gen #(.AW(AW)) u_addr_gen (
      .addr_i      (addr_q),
      .size_i      (size_q),
      .len_i       (len_q),
      .burst_i     (burst_q),
      .next_addr_o (next_addr_d)
   );

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         size_q      <= '0;
         burst_q     <= '0;
         id_q        <= '0;
         aw_err_q    <= 1'b0;
         wl_err_q    <= 1'b0;
         awready_q   <= 1'b0;
         wready_q    <= 1'b0;
         bvalid_q    <= 1'b0;
         bresp_q     <= '0;
         bid_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
      end else begin
         mem_we_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               awready_q <= 1'b1;
               if (AWVALID && awready_q) begin
                  addr_q    <= AWADDR;
                  len_q     <= AWLEN;
                  size_q    <= AWSIZE;
                  burst_q   <= AWBURST;
                  id_q      <= AWID;
                  cnt_q     <= '0;
                  aw_err_q  <= aw_err_d;
                  wl_err_q  <= 1'b0;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  state_q   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (WVALID && wready_q) begin
                  // Illegal bursts still drain their beats but never touch memory.
                  mem_we_q    <= !aw_err_q;
                  mem_addr_q  <= addr_q;
                  mem_wdata_q <= WDATA;
                  mem_wstrb_q <= WSTRB;
                  addr_q      <= next_addr_d;
                  cnt_q       <= cnt_q + 8'd1;
                  if (wlast_bad_d) wl_err_q <= 1'b1;
                  if (last_beat_d) begin
                     wready_q <= 1'b0;
                     bvalid_q <= 1'b1;
                     bid_q    <= id_q;
                     bresp_q  <= (aw_err_q || wl_err_q || wlast_bad_d) ? RESP_SLVERR : RESP_OKAY;
                     state_q  <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               if (BREADY) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  state_q   <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign AWREADY   = awready_q;
   assign WREADY    = wready_q;
   assign BVALID    = bvalid_q;
   assign BID       = bid_q;
   assign BRESP     = bresp_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_rh_axi4_slv_wr_ctrl.sv
// tb/tb_rh_axi4_slv_wr_ctrl.sv - directed self-checking bench for rh_axi4_slv_wr_ctrl
module tb_rh_axi4_slv_wr_ctrl;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = 4;

   logic            ACLK = 1'b0;
   logic            ARESETN;
   logic            AWVALID;
   logic            AWREADY;
   logic [AW-1:0]   AWADDR;
   logic [7:0]      AWLEN;
   logic [2:0]      AWSIZE;
   logic [1:0]      AWBURST;
   logic [IW-1:0]   AWID;
   logic            WVALID;
   logic            WREADY;
   logic [DW-1:0]   WDATA;
   logic [DW/8-1:0] WSTRB;
   logic            WLAST;
   logic            BVALID;
   logic            BREADY;
   logic [IW-1:0]   BID;
   logic [1:0]      BRESP;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW/8-1:0] mem_wstrb;

   int checks = 0;
   int errors = 0;

   logic [AW-1:0]   wa_q[$];
   logic [DW-1:0]   wd_q[$];
   logic [DW/8-1:0] ws_q[$];

   rh_axi4_slv_wr_ctrl #(.AW(AW), .DW(DW), .IW(IW)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
      .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWID(AWID),
      .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
      .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
   );

   always #5 ACLK = ~ACLK;

   always @(negedge ACLK) begin
      if (mem_we) begin
         wa_q.push_back(mem_addr);
         wd_q.push_back(mem_wdata);
         ws_q.push_back(mem_wstrb);
      end
   end

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs AW plus all W beats; completes the B handshake only when BREADY is already 1.
   task automatic burst(input string tag, input logic [AW-1:0] a, input logic [7:0] len,
                        input logic [2:0] sz, input logic [1:0] bt, input logic [IW-1:0] id,
                        input int gap_beat, input int bad_last_beat,
                        output logic [1:0] resp, output logic [IW-1:0] bid);
      int n;
      wa_q.delete();
      wd_q.delete();
      ws_q.delete();
      AWADDR  = a;
      AWLEN   = len;
      AWSIZE  = sz;
      AWBURST = bt;
      AWID    = id;
      AWVALID = 1'b1;
      n = 0;
      while (!AWREADY && n < 50) begin tick(); n++; end
      if (n >= 50) chk({tag, "_aw_timeout"}, 1'b1, 1'b0);
      tick();
      AWVALID = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         if (b == gap_beat) begin
            WVALID = 1'b0;
            tick();
            tick();
         end
         WVALID = 1'b1;
         WDATA  = 32'hD000_0000 + 32'(b);
         WSTRB  = 4'(b + 1);
         WLAST  = (b == int'(len)) ^ (b == bad_last_beat);
         n = 0;
         while (!WREADY && n < 50) begin tick(); n++; end
         if (n >= 50) chk({tag, "_w_timeout"}, 1'b1, 1'b0);
         tick();
      end
      WVALID = 1'b0;
      WLAST  = 1'b0;
      chk({tag, "_bvalid_latency"}, BVALID, 1'b1);
      chk({tag, "_wready_off"}, WREADY, 1'b0);
      resp = BRESP;
      bid  = BID;
      if (BREADY) begin
         tick();
         tick();
         chk({tag, "_bvalid_clr"}, BVALID, 1'b0);
         chk({tag, "_awready_back"}, AWREADY, 1'b1);
      end
   endtask

   logic [1:0]    r;
   logic [IW-1:0] id;
   int            wcnt;

   initial begin
      ARESETN = 1'b0;
      AWVALID = 1'b0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWID = '0;
      WVALID = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0;
      BREADY = 1'b1;
      tick();
      tick();
      chk("rst_awready", AWREADY, 1'b0);
      chk("rst_wready", WREADY, 1'b0);
      chk("rst_bvalid", BVALID, 1'b0);
      chk("rst_bresp", BRESP, 2'b00);
      chk("rst_bid", BID, '0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, '0);
      chk("rst_mem_wdata", mem_wdata, '0);
      chk("rst_mem_wstrb", mem_wstrb, '0);
      ARESETN = 1'b1;
      chk("rel_awready_pre", AWREADY, 1'b0);
      tick();
      chk("rel_awready_post", AWREADY, 1'b1);

      // INCR aligned
      burst("incr", 32'h100, 8'd3, 3'd2, 2'b01, 4'h5, -1, -1, r, id);
      chk("incr_n", wa_q.size(), 4);
      chk("incr_a0", wa_q[0], 32'h100);
      chk("incr_a1", wa_q[1], 32'h104);
      chk("incr_a2", wa_q[2], 32'h108);
      chk("incr_a3", wa_q[3], 32'h10C);
      chk("incr_d0", wd_q[0], 32'hD000_0000);
      chk("incr_d2", wd_q[2], 32'hD000_0002);
      chk("incr_s2", ws_q[2], 4'h3);
      chk("incr_resp", r, 2'b00);
      chk("incr_bid", id, 4'h5);

      // WRAP
      burst("wrap", 32'h108, 8'd3, 3'd2, 2'b10, 4'h3, -1, -1, r, id);
      chk("wrap_n", wa_q.size(), 4);
      chk("wrap_a0", wa_q[0], 32'h108);
      chk("wrap_a1", wa_q[1], 32'h10C);
      chk("wrap_a2", wa_q[2], 32'h100);
      chk("wrap_a3", wa_q[3], 32'h104);
      chk("wrap_resp", r, 2'b00);
      chk("wrap_bid", id, 4'h3);

      // FIXED with a WVALID gap before beat 1
      burst("fixed", 32'h20, 8'd2, 3'd2, 2'b00, 4'h7, 1, -1, r, id);
      chk("fixed_n", wa_q.size(), 3);
      chk("fixed_a0", wa_q[0], 32'h20);
      chk("fixed_a1", wa_q[1], 32'h20);
      chk("fixed_a2", wa_q[2], 32'h20);
      chk("fixed_resp", r, 2'b00);

      // Unaligned INCR start: later beats aligned down
      burst("unal", 32'h102, 8'd1, 3'd2, 2'b01, 4'h1, -1, -1, r, id);
      chk("unal_n", wa_q.size(), 2);
      chk("unal_a0", wa_q[0], 32'h102);
      chk("unal_a1", wa_q[1], 32'h104);

      // Oversize beat: no memory writes, SLVERR
      burst("size", 32'h40, 8'd1, 3'd3, 2'b01, 4'h9, -1, -1, r, id);
      chk("size_n", wa_q.size(), 0);
      chk("size_resp", r, 2'b10);
      chk("size_bid", id, 4'h9);

      // Illegal WRAP length
      burst("wraplen", 32'h80, 8'd2, 3'd2, 2'b10, 4'h2, -1, -1, r, id);
      chk("wraplen_n", wa_q.size(), 0);
      chk("wraplen_resp", r, 2'b10);

      // Reserved burst type
      burst("rsvd", 32'h200, 8'd1, 3'd2, 2'b11, 4'h4, -1, -1, r, id);
      chk("rsvd_n", wa_q.size(), 0);
      chk("rsvd_resp", r, 2'b10);

      // Early WLAST on beat 1
      burst("wlast", 32'h500, 8'd3, 3'd2, 2'b01, 4'h6, -1, 1, r, id);
      chk("wlast_n", wa_q.size(), 4);
`ifdef RH_AXI4_SLV_WLAST_CHECK_EN
      chk("wlast_resp", r, 2'b10);
`else
      chk("wlast_resp", r, 2'b00);
`endif

      // Single beat with BREADY held low
      BREADY = 1'b0;
      burst("hold", 32'h300, 8'd0, 3'd2, 2'b01, 4'hA, -1, -1, r, id);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("hold_bvalid", BVALID, 1'b1);
         chk("hold_bid", BID, 4'hA);
         chk("hold_bresp", BRESP, 2'b00);
         chk("hold_awready", AWREADY, 1'b0);
      end
      chk("hold_n", wa_q.size(), 1);
      chk("hold_a0", wa_q[0], 32'h300);
      BREADY = 1'b1;
      tick();
      chk("hold_release", BVALID, 1'b0);

      // Reset in the middle of a burst
      wa_q.delete();
      tick();
      AWADDR = 32'h400; AWLEN = 8'd3; AWSIZE = 3'd2; AWBURST = 2'b01; AWID = 4'hC;
      AWVALID = 1'b1;
      tick();
      AWVALID = 1'b0;
      chk("mid_in_data", WREADY, 1'b1);
      WVALID = 1'b1; WDATA = 32'h1234_5678; WSTRB = 4'hF;
      tick();
      WVALID = 1'b0;
      tick();
      wcnt = wa_q.size();
      chk("mid_pre_n", wcnt, 1);
      WVALID = 1'b1;
      ARESETN = 1'b0;
      #1;
      chk("mid_awready", AWREADY, 1'b0);
      chk("mid_wready", WREADY, 1'b0);
      chk("mid_bvalid", BVALID, 1'b0);
      chk("mid_mem_addr", mem_addr, '0);
      chk("mid_mem_wdata", mem_wdata, '0);
      tick();
      tick();
      WVALID = 1'b0;
      ARESETN = 1'b1;
      tick();
      chk("mid_awready_post", AWREADY, 1'b1);
      tick();
      tick();
      chk("mid_no_bvalid", BVALID, 1'b0);
      chk("mid_no_writes", wa_q.size(), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
